// File: rtl/hazard_controller.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use stall, branch flush and data-memory wait FSM with timeout watchdog.
// Optional performance counters (stall_cycles, flush_events) are compiled in when HAZARD_PERF_CNT_EN is defined.
module hazard_controller #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       rs1_used_id,
    input  logic       rs2_used_id,
    input  logic [4:0] rd_exe,
    input  logic       mem_read_exe,
    input  logic       branch_taken_exe,
    input  logic       dmem_req_mem,
    input  logic       dmem_ack,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_exe,
    output logic       stall_mem,
    output logic       flush_id,
    output logic       flush_exe,
    output logic       flush_wb,
    output logic       bus_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_MEM_ERR  = 2'd2;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_TO   = CW'(MEM_TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          bus_err_q, bus_err_d;
    logic          freeze_s, timeout_s;
    logic          load_use_s, lu_s, br_s;

    // Memory-wait FSM next state, freeze and watchdog timeout
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze_s   = 1'b0;
        timeout_s  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (dmem_req_mem && !dmem_ack) begin
                    freeze_s   = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = CNT_ONE;
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = CNT_ZERO;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ack) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = CNT_ZERO;
                end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == CNT_TO)) begin
                    // Faulted access is dropped: pipeline released, MEM/WB bubbled
                    timeout_s  = 1'b1;
                    state_d    = ST_MEM_ERR;
                    wait_cnt_d = CNT_ZERO;
                end else begin
                    freeze_s = 1'b1;
                    if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + CNT_ONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end
                end
            end
            ST_MEM_ERR: begin
                state_d    = ST_RUN;
                wait_cnt_d = CNT_ZERO;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = CNT_ZERO;
            end
        endcase
        bus_err_d = (state_d == ST_MEM_ERR);
    end

    // State, wait counter and registered bus error pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= CNT_ZERO;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign load_use_s = mem_read_exe && (rd_exe != 5'd0) &&
                        ((rs1_used_id && (rs1_id == rd_exe)) ||
                         (rs2_used_id && (rs2_id == rd_exe)));

    // Hazard detection is masked while frozen; a branch overrides a load-use stall
    assign br_s = branch_taken_exe && !freeze_s;
    assign lu_s = load_use_s && !freeze_s && !branch_taken_exe;

    assign stall_if  = reset_n && (freeze_s || lu_s);
    assign stall_id  = reset_n && (freeze_s || lu_s);
    assign stall_exe = reset_n && freeze_s;
    assign stall_mem = reset_n && freeze_s;
    assign flush_id  = reset_n && br_s;
    assign flush_exe = reset_n && (br_s || lu_s);
    assign flush_wb  = reset_n && (freeze_s || timeout_s);
    assign bus_err   = bus_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_events_q;

    // Free-running performance counters, wrapping at 2^32
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_q + {31'd0, stall_if};
            flush_events_q <= flush_events_q + {31'd0, flush_id};
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (MEM_TIMEOUT=4): vector table plus wait/timeout/reset sequences.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rs1_id, rs2_id, rd_exe;
    logic       rs1_used_id, rs2_used_id, mem_read_exe, branch_taken_exe;
    logic       dmem_req_mem, dmem_ack;
    logic       stall_if, stall_id, stall_exe, stall_mem;
    logic       flush_id, flush_exe, flush_wb, bus_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_controller #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_exe(rd_exe), .mem_read_exe(mem_read_exe),
        .branch_taken_exe(branch_taken_exe),
        .dmem_req_mem(dmem_req_mem), .dmem_ack(dmem_ack),
        .stall_if(stall_if), .stall_id(stall_id),
        .stall_exe(stall_exe), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_exe(flush_exe),
        .flush_wb(flush_wb), .bus_err(bus_err)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    // Output vector: {stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe, flush_wb, bus_err}
    localparam logic [7:0] E_NONE   = 8'b0000_0000;
    localparam logic [7:0] E_LU     = 8'b1100_0100;
    localparam logic [7:0] E_BR     = 8'b0000_1100;
    localparam logic [7:0] E_FREEZE = 8'b1111_0010;
    localparam logic [7:0] E_TO     = 8'b0000_0010;
    localparam logic [7:0] E_BERR   = 8'b0000_0001;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, br, req, ack;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [7:0] outs();
        return {stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe, flush_wb, bus_err};
    endfunction

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = outs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic mr, input logic br,
                         input logic req, input logic ack);
        rs1_id = rs1; rs2_id = rs2; rd_exe = rd;
        rs1_used_id = u1; rs2_used_id = u2; mem_read_exe = mr;
        branch_taken_exe = br; dmem_req_mem = req; dmem_ack = ack;
    endtask

    // Drive a cycle's inputs just after posedge and check at the following negedge
    task automatic cycle(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2, input logic mr,
                         input logic br, input logic req, input logic ack, input logic [7:0] exp);
        @(posedge clk);
        #1;
        drive(rs1, rs2, rd, u1, u2, mr, br, req, ack);
        @(negedge clk);
        check(name, exp);
    endtask

    initial begin
        vecs[0]  = '{rs1:5'd5,  rs2:5'd0,  rd:5'd5,  u1:1'b1, u2:1'b0, mr:1'b1, br:1'b0, req:1'b0, ack:1'b0, exp:E_LU};
        vecs[1]  = '{rs1:5'd5,  rs2:5'd0,  rd:5'd5,  u1:1'b1, u2:1'b0, mr:1'b0, br:1'b0, req:1'b0, ack:1'b0, exp:E_NONE};
        vecs[2]  = '{rs1:5'd0,  rs2:5'd0,  rd:5'd0,  u1:1'b1, u2:1'b1, mr:1'b1, br:1'b0, req:1'b0, ack:1'b0, exp:E_NONE};
        vecs[3]  = '{rs1:5'd3,  rs2:5'd7,  rd:5'd7,  u1:1'b1, u2:1'b0, mr:1'b1, br:1'b0, req:1'b0, ack:1'b0, exp:E_NONE};
        vecs[4]  = '{rs1:5'd3,  rs2:5'd7,  rd:5'd7,  u1:1'b1, u2:1'b1, mr:1'b1, br:1'b0, req:1'b0, ack:1'b0, exp:E_LU};
        vecs[5]  = '{rs1:5'd5,  rs2:5'd0,  rd:5'd5,  u1:1'b1, u2:1'b0, mr:1'b1, br:1'b1, req:1'b0, ack:1'b0, exp:E_BR};
        vecs[6]  = '{rs1:5'd1,  rs2:5'd2,  rd:5'd9,  u1:1'b1, u2:1'b1, mr:1'b0, br:1'b1, req:1'b0, ack:1'b0, exp:E_BR};
        vecs[7]  = '{rs1:5'd9,  rs2:5'd9,  rd:5'd9,  u1:1'b1, u2:1'b1, mr:1'b0, br:1'b0, req:1'b0, ack:1'b0, exp:E_NONE};
        vecs[8]  = '{rs1:5'd5,  rs2:5'd0,  rd:5'd5,  u1:1'b1, u2:1'b0, mr:1'b1, br:1'b0, req:1'b1, ack:1'b1, exp:E_LU};
        vecs[9]  = '{rs1:5'd0,  rs2:5'd0,  rd:5'd0,  u1:1'b0, u2:1'b0, mr:1'b0, br:1'b0, req:1'b1, ack:1'b1, exp:E_NONE};
        vecs[10] = '{rs1:5'd31, rs2:5'd31, rd:5'd31, u1:1'b0, u2:1'b1, mr:1'b1, br:1'b0, req:1'b0, ack:1'b0, exp:E_LU};
        vecs[11] = '{rs1:5'd4,  rs2:5'd6,  rd:5'd5,  u1:1'b1, u2:1'b1, mr:1'b1, br:1'b0, req:1'b0, ack:1'b0, exp:E_NONE};

        // Reset with hazards and a pending memory stall present: everything must stay quiet
        reset_n = 1'b0;
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        check("reset_outputs", E_NONE);
        @(negedge clk);
        check("reset_outputs_clocked", E_NONE);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].u1, vecs[i].u2, vecs[i].mr, vecs[i].br,
                  vecs[i].req, vecs[i].ack, vecs[i].exp);
        end

        // Three wait states then ack; hazards masked while frozen, branch honoured on release
        cycle("wait_c0", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FREEZE);
        cycle("wait_c1_masked", 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, E_FREEZE);
        cycle("wait_c2", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FREEZE);
        cycle("wait_ack_branch", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, E_BR);
        cycle("wait_after_ack", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
        cycle("wait_back_in_run", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE);

        // Timeout at 4: four freeze cycles, release with flush_wb, then one bus_err pulse
        for (int i = 0; i < 4; i++) begin
            cycle($sformatf("to_freeze%0d", i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FREEZE);
        end
        cycle("to_release", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_TO);
        cycle("to_bus_err", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_BERR);
        cycle("to_bus_err_gone", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);
        cycle("to_run_load_use", 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_LU);

        // Reset on the second MEM_WAIT cycle
        cycle("rst_wait_c0", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FREEZE);
        cycle("rst_wait_c1", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FREEZE);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_immediate", E_NONE);
        @(negedge clk);
        check("rst_held", E_NONE);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("rst_no_bus_err%0d", i), E_NONE);
        end
        // Counter cleared by reset: a full three-cycle wait must not time out
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("rst_rewait%0d", i), 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_FREEZE);
        end
        cycle("rst_rewait_ack", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE);
        cycle("rst_rewait_idle", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
